// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin request/grant arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Sized for the widest legal requester count; callers zero-extend and slice.
    function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req_mask at or after start, wrapping.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_mask,
    input  logic [IW-1:0]    start,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && req_mask[(int'(start) + i) % N_REQ]) begin
                valid  = 1'b1;
                winner = IW'((int'(start) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter with per-owner hold limit, done release and preemption pulse.
module rr_req_gnt_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic                     done,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     preempt
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             preempt_q, preempt_d;

    logic [3:0]       owner_full;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    start;
    logic             owner_req;
    logic             hold_exp;
    logic             release_now;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;

    assign owner_full  = onehot2idx(16'(gnt_q));
    assign owner       = owner_full[IW-1:0];
    assign owner_req   = req[owner];
    assign hold_exp    = (hold_q == HW'(MAX_HOLD - 1));
    assign release_now = done | ~owner_req | hold_exp;
    assign start       = (last_q == IW'(N_REQ - 1)) ? '0 : last_q + IW'(1);

    // Starting after the last owner puts the releasing owner last in line, so it
    // only wins again when nobody else is requesting.
    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_mask (req),
        .start    (start),
        .valid    (pick_valid),
        .winner   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    last_d  = pick_idx;
                    hold_d  = '0;
                end
            end
            OWN: begin
                if (release_now) begin
                    preempt_d = hold_exp & ~done & owner_req;
                    hold_d    = '0;
                    if (pick_valid) begin
                        gnt_d  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        last_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= IW'(N_REQ - 1);
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = owner;
    assign busy    = |gnt_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Scoreboard bench for rr_req_gnt_arbiter with hand-computed directed vectors.
module tb_rr_req_gnt_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       preempt;

    typedef struct {
        logic [3:0] gnt;
        logic       pre;
        int         n;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   row_n    = 0;

    rr_req_gnt_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // One vector: inputs for this cycle and the outputs expected after the next edge.
    task automatic row(input logic r, input logic [3:0] rq, input logic d,
                       input logic [3:0] eg, input logic ep);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = d;
        e.gnt = eg;
        e.pre = ep;
        e.n   = row_n;
        row_n++;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        row(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
        row(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        logic [4:0] act, req_v;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act   = {gnt, busy};
                req_v = {e.gnt, (e.gnt != 4'b0000)};
                n_checks++;
                if (act == req_v && gnt_id == idx_of(e.gnt) && preempt == e.pre) begin
                    n_pass++;
                end else begin
                    $display("FAIL row%0d: gnt=%b gnt_id=%0d busy=%b preempt=%b, expected gnt=%b gnt_id=%0d busy=%b preempt=%b",
                             e.n, gnt, gnt_id, busy, preempt, e.gnt, idx_of(e.gnt),
                             (e.gnt != 4'b0000), e.pre);
                end
            end
        end
    end

    initial begin : driver
        int wait_cyc;
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        // Lone request, then release by dropping req; done with no owner is ignored.
        do_reset();
        row(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        row(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Rotation with done every second owner cycle: 0,1,2,3,0 with no gaps.
        do_reset();
        row(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0);
        row(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0);
        row(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0);
        row(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0);
        row(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0);
        row(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0);
        row(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        row(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Hold limit: owner 0 for 8 cycles, preempt on handoff to 1, then back to 0.
        do_reset();
        row(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 7; i++) row(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1);
        for (int i = 0; i < 7; i++) row(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b0);
        row(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1);
        row(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Sole hog: preempt every 8 cycles, grant never drops.
        do_reset();
        row(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 7; i++) row(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
            row(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
        end
        row(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // done coinciding with hold expiry: normal handoff, no preempt.
        do_reset();
        row(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 7; i++) row(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b0011, 1'b1, 4'b0010, 1'b0);
        row(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Mid-grant reset, then requester 0 wins first in the deassert cycle.
        do_reset();
        row(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0);
        row(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
        row(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Non-owner request churn leaves the grant alone; sole requester regranted on done.
        do_reset();
        row(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b1011, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b0101, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
        row(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0);
        row(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b0);
        row(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #5;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_req_gnt_arbiter.md
RR_REQ_GNT_ARBITER -- requirements
Module: rr_req_gnt_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner; legal range 2..255.
REQ-003 Port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, N_REQ: per-requester request level; bit i high means requester i wants the resource.
REQ-006 Port done, input, 1: current owner releases the resource this cycle; ignored when no grant is active.
REQ-007 Port gnt, output, N_REQ: registered one-hot grant vector, or all-zero.
REQ-008 Port gnt_id, output, $clog2(N_REQ): index of the current owner; 0 when gnt is zero.
REQ-009 Port busy, output, 1: high exactly when gnt is non-zero.
REQ-010 Port preempt, output, 1: one-cycle pulse in the cycle a grant ends by hold-limit expiry.

Function
REQ-011 The FSM SHALL have two states: IDLE (no owner) and OWN (one owner).
REQ-012 IDLE -> OWN: if req is non-zero in cycle t, gnt SHALL be one-hot at t+1, selected by round-robin pick; this guarantees req |=> gnt for an idle arbiter.
REQ-013 Round-robin pick: search order starts at index (last_owner+1) mod N_REQ and wraps; last_owner resets to N_REQ-1, so requester 0 wins first after reset.
REQ-014 In OWN the grant SHALL be released in cycle t when any of these hold: done=1; req[owner]=0; hold_cnt=MAX_HOLD-1.
REQ-015 On release at t, if any other req bit is set, gnt SHALL switch to the next pick at t+1 with no idle cycle; the released owner is excluded unless it is the only requester.
REQ-016 On release at t with no eligible requester, gnt SHALL be zero at t+1 and the state returns to IDLE.
REQ-017 hold_cnt SHALL be cleared on every new grant, increment each OWN cycle, and saturate; its width is $clog2(MAX_HOLD+1).
REQ-018 preempt SHALL pulse at t+1 only when the release at t was caused solely by hold_cnt expiry (done=0 and req[owner]=1).
REQ-019 When done and hold expiry coincide, the release SHALL be treated as done and preempt SHALL stay 0.
REQ-020 last_owner SHALL update to the owner index whenever a new grant is issued.
REQ-021 gnt SHALL never have more than one bit set in any cycle.
REQ-022 Request changes of non-owners SHALL NOT affect the current grant.

Reset
REQ-023 With rst=1 at a clock edge, the next cycle SHALL show gnt=0, gnt_id=0, busy=0, preempt=0, state IDLE, hold_cnt=0 and last_owner=N_REQ-1.
REQ-024 Reset asserted during OWN SHALL drop the grant at the next edge regardless of done or req.
REQ-025 req sampled in the cycle rst deasserts SHALL be arbitrated normally; gnt may appear one cycle later.

Structure
REQ-026 Package rr_arb_pkg SHALL hold the state enum (IDLE, OWN) and the helper function for one-hot-to-index conversion.
REQ-027 Sub-module rr_pick (combinational rotating-priority picker: inputs req mask and start index; outputs valid and winner index) SHALL be instantiated once.

Verification
REQ-028 Lone request: req=0001 at t -> gnt=0001, gnt_id=0, busy=1 at t+1.
REQ-029 Rotation: req=1111 held, done pulsed every 2nd OWN cycle -> owners 0,1,2,3,0 in order with no gap cycles.
REQ-030 Hold limit: MAX_HOLD=8, req=0011 held, done=0 -> owner 0 for 8 cycles, preempt=1 in the cycle gnt becomes 0010.
REQ-031 Sole hog: req=0100 held, done=0 -> preempt pulses every 8 cycles, gnt stays 0100 with no gap.
REQ-032 Simultaneous events: done=1 and hold_cnt=7 in the same cycle -> preempt=0 and a normal handoff.
REQ-033 Mid-grant reset: rst=1 during OWN with req=1111 -> all outputs 0 next cycle; after release, requester 0 is granted first.
